vga_edit_ctrl: RTL

//  Sequences the clock/date/stopwatch display overlay. Tracks active view (hora/fecha/crono) and

---
 rtl/vga_edit_ctrl_if.sv | 42 ++++
 rtl/vga_edit_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_edit_ctrl_if.sv
// Button/alarm inputs and display-overlay outputs exchanged between the
// button front end (master) and the edit controller (slave).
interface vga_edit_ctrl_if;
    logic       btn_mode;
    logic       btn_prog;
    logic       btn_der;
    logic       btn_izq;
    logic       btn_stop;
    logic       crono_fin;

    logic [1:0] vista;
    logic       prog_activo;
    logic [1:0] campo;
    logic       bandera_Hhora;
    logic       bandera_Mhora;
    logic       bandera_Shora;
    logic       bandera_Dfecha;
    logic       bandera_Mfecha;
    logic       bandera_Afecha;
    logic       bandera_Hcrono;
    logic       bandera_Mcrono;
    logic       bandera_Scrono;
    logic       activring;

    modport master (
        output btn_mode, btn_prog, btn_der, btn_izq, btn_stop, crono_fin,
        input  vista, prog_activo, campo,
               bandera_Hhora, bandera_Mhora, bandera_Shora,
               bandera_Dfecha, bandera_Mfecha, bandera_Afecha,
               bandera_Hcrono, bandera_Mcrono, bandera_Scrono,
               activring
    );

    modport slave (
        input  btn_mode, btn_prog, btn_der, btn_izq, btn_stop, crono_fin,
        output vista, prog_activo, campo,
               bandera_Hhora, bandera_Mhora, bandera_Shora,
               bandera_Dfecha, bandera_Mfecha, bandera_Afecha,
               bandera_Hcrono, bandera_Mcrono, bandera_Scrono,
               activring
    );
endinterface

// File: rtl/vga_edit_ctrl.sv
// Clock/date/stopwatch overlay sequencer: view selection, programming-mode
// cursor with blinking field highlight, and the stopwatch alarm indicator.
module vga_edit_ctrl #(
    parameter int unsigned BLINK_HALF   = 25_000_000,
    parameter int unsigned EDIT_TIMEOUT = 500_000_000,
    parameter int unsigned RING_CYCLES  = 1_000_000_000
) (
    input  logic           clk,
    input  logic           reset,
    vga_edit_ctrl_if.slave bus
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned NFLAGS = 9;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EDIT_HORA  = 2'd1,
        EDIT_FECHA = 2'd2,
        EDIT_CRONO = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         vista_q, vista_d;
    logic [1:0]         campo_q, campo_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               prog_q, prog_d;
    logic [NFLAGS-1:0]  flags_q, flags_d;
    logic               ring_q, ring_d;
    logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_d;

    logic               any_btn;
    logic               move_fwd;
    logic               move_bwd;
    logic [3:0]         flag_idx;

    function automatic state_t edit_state(input logic [1:0] v);
        case (v)
            2'd0:    return EDIT_HORA;
            2'd1:    return EDIT_FECHA;
            default: return EDIT_CRONO;
        endcase
    endfunction

    // btn_stop counts as activity for the edit timeout even though the FSM ignores it
    assign any_btn  = bus.btn_mode | bus.btn_prog | bus.btn_der | bus.btn_izq | bus.btn_stop;
    assign move_fwd = bus.btn_der & ~bus.btn_izq;
    assign move_bwd = bus.btn_izq & ~bus.btn_der;

    always_comb begin
        state_d     = state_q;
        vista_d     = vista_q;
        campo_d     = campo_q;
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                campo_d     = 2'd0;
                phase_d     = 1'b1;
                blink_cnt_d = '0;
                tmo_cnt_d   = '0;
                if (bus.btn_prog) begin
                    state_d = edit_state(vista_q);
                end else if (bus.btn_mode) begin
                    vista_d = (vista_q == 2'd2) ? 2'd0 : 2'(vista_q + 2'd1);
                end
            end

            EDIT_HORA, EDIT_FECHA, EDIT_CRONO: begin
                if (bus.btn_prog) begin
                    state_d     = IDLE;
                    campo_d     = 2'd0;
                    phase_d     = 1'b1;
                    blink_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end else begin
                    if (move_fwd || move_bwd) begin
                        if (move_fwd) begin
                            campo_d = (campo_q == 2'd2) ? 2'd0 : 2'(campo_q + 2'd1);
                        end else begin
                            campo_d = (campo_q == 2'd0) ? 2'd2 : 2'(campo_q - 2'd1);
                        end
                        phase_d     = 1'b1;
                        blink_cnt_d = '0;
                    end else if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
                        phase_d     = ~phase_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = CNT_W'(blink_cnt_q + CNT_W'(1));
                    end

                    // Silent edit session times out back to IDLE
                    if (any_btn) begin
                        tmo_cnt_d = '0;
                    end else if (tmo_cnt_q == CNT_W'(EDIT_TIMEOUT - 1)) begin
                        state_d     = IDLE;
                        campo_d     = 2'd0;
                        phase_d     = 1'b1;
                        blink_cnt_d = '0;
                        tmo_cnt_d   = '0;
                    end else begin
                        tmo_cnt_d = CNT_W'(tmo_cnt_q + CNT_W'(1));
                    end
                end
            end
        endcase
    end

    // Highlight decode from next-cycle state so flags line up with vista/campo
    always_comb begin
        prog_d   = (state_d != IDLE);
        flag_idx = 4'(4'(vista_d) * 4'd3 + 4'(campo_d));
        flags_d  = '0;
        if (prog_d && phase_d) begin
            flags_d[flag_idx] = 1'b1;
        end
    end

    // Alarm runs independently of the edit FSM; a new crono_fin always restarts it
    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (bus.crono_fin) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end else if (ring_q) begin
            if (bus.btn_stop || (ring_cnt_q == CNT_W'(RING_CYCLES - 1))) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else begin
                ring_cnt_d = CNT_W'(ring_cnt_q + CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vista_q     <= 2'd0;
            campo_q     <= 2'd0;
            phase_q     <= 1'b1;
            blink_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            prog_q      <= 1'b0;
            flags_q     <= '0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            vista_q     <= vista_d;
            campo_q     <= campo_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            prog_q      <= prog_d;
            flags_q     <= flags_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
        end
    end

    assign bus.vista          = vista_q;
    assign bus.prog_activo    = prog_q;
    assign bus.campo          = campo_q;
    assign bus.bandera_Hhora  = flags_q[0];
    assign bus.bandera_Mhora  = flags_q[1];
    assign bus.bandera_Shora  = flags_q[2];
    assign bus.bandera_Dfecha = flags_q[3];
    assign bus.bandera_Mfecha = flags_q[4];
    assign bus.bandera_Afecha = flags_q[5];
    assign bus.bandera_Hcrono = flags_q[6];
    assign bus.bandera_Mcrono = flags_q[7];
    assign bus.bandera_Scrono = flags_q[8];
    assign bus.activring      = ring_q;

endmodule
